// File: rtl/alu_result_reg.sv
// Result register behind the 8-bit ALU, with synchronized capture and scroll buttons.
// Define ALU_HIST_EN to add the scrollable ring-buffer history of captured results.
module alu_result_reg #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int CNT_W      = IDX_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_in,
  input  logic             key_n,
  input  logic             scroll_n,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             cap_pulse,
  output logic [WIDTH-1:0] hist_q,
  output logic [IDX_W-1:0] hist_idx,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [SYNC_STAGES-1:0] key_sync_q, key_sync_d;
  logic                   key_edge_q, key_edge_d;
  logic                   cap_q, cap_d;
  logic [WIDTH-1:0]       q_q, q_d;

  // Sync and edge flops reset to "pressed" so a key held through reset never fires.
  always_comb begin
    key_sync_d = {key_sync_q[SYNC_STAGES-2:0], key_n};
    key_edge_d = key_sync_q[SYNC_STAGES-1];
    cap_d      = key_edge_q & ~key_sync_q[SYNC_STAGES-1];
    q_d        = cap_q ? alu_in : q_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_sync_q <= '0;
      key_edge_q <= 1'b0;
      cap_q      <= 1'b0;
      q_q        <= '0;
    end else begin
      key_sync_q <= key_sync_d;
      key_edge_q <= key_edge_d;
      cap_q      <= cap_d;
      q_q        <= q_d;
    end
  end

  assign q         = q_q;
  assign cap_pulse = cap_q;

`ifdef ALU_HIST_EN
  logic [SYNC_STAGES-1:0] scr_sync_q, scr_sync_d;
  logic                   scr_edge_q, scr_edge_d;
  logic                   scr_q, scr_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [WIDTH-1:0]       mem_d [DEPTH];
  logic [IDX_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]       hist_idx_q, hist_idx_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [IDX_W-1:0]       rd_ptr;

  always_comb begin
    scr_sync_d = {scr_sync_q[SYNC_STAGES-2:0], scroll_n};
    scr_edge_d = scr_sync_q[SYNC_STAGES-1];
    scr_d      = scr_edge_q & ~scr_sync_q[SYNC_STAGES-1];
  end

  // Priority clear > capture > scroll; a clear with a capture refills slot 0.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    hist_idx_d = hist_idx_q;
    if (clear) begin
      wr_ptr_d   = '0;
      count_d    = '0;
      hist_idx_d = '0;
      if (cap_q) begin
        mem_d[0] = alu_in;
        wr_ptr_d = IDX_W'(1);
        count_d  = CNT_W'(1);
      end
    end else if (cap_q) begin
      mem_d[wr_ptr_q] = alu_in;
      wr_ptr_d        = wr_ptr_q + IDX_W'(1);
      hist_idx_d      = '0;
      if (count_q != CNT_W'(DEPTH))
        count_d = count_q + CNT_W'(1);
    end else if (scr_q && count_q != '0) begin
      if (({1'b0, hist_idx_q} + CNT_W'(1)) == count_q)
        hist_idx_d = '0;
      else
        hist_idx_d = hist_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scr_sync_q <= '0;
      scr_edge_q <= 1'b0;
      scr_q      <= 1'b0;
      wr_ptr_q   <= '0;
      hist_idx_q <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      scr_sync_q <= scr_sync_d;
      scr_edge_q <= scr_edge_d;
      scr_q      <= scr_d;
      wr_ptr_q   <= wr_ptr_d;
      hist_idx_q <= hist_idx_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Newest entry sits just behind the write pointer.
  assign rd_ptr = wr_ptr_q - IDX_W'(1) - hist_idx_q;

  always_comb begin
    hist_q = '0;
    if (count_q != '0) hist_q = mem_q[rd_ptr];
  end

  assign hist_idx = hist_idx_q;
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
`else
  logic have_cap_q, have_cap_d;
  logic unused_inputs;

  assign have_cap_d    = have_cap_q | cap_q;
  assign unused_inputs = scroll_n ^ clear;

  always_ff @(posedge clk) begin
    if (reset) have_cap_q <= 1'b0;
    else       have_cap_q <= have_cap_d;
  end

  assign hist_q   = q_q;
  assign hist_idx = '0;
  assign count    = {{IDX_W{1'b0}}, have_cap_q};
  assign full     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_reg.sv
// Directed self-checking bench for alu_result_reg; covers both ALU_HIST_EN builds.
module tb_alu_result_reg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_in;
  logic       key_n;
  logic       scroll_n;
  logic       clear;
  logic [7:0] q;
  logic       cap_pulse;
  logic [7:0] hist_q;
  logic [1:0] hist_idx;
  logic [2:0] count;
  logic       full;

  int total = 0;
  int bad   = 0;
  int pulses;

  alu_result_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .alu_in(alu_in), .key_n(key_n),
    .scroll_n(scroll_n), .clear(clear), .q(q), .cap_pulse(cap_pulse),
    .hist_q(hist_q), .hist_idx(hist_idx), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press capture (optionally with scroll and/or a clear aligned to the capture edge).
  task automatic applyStimulus(input logic [7:0] val, input bit with_scroll, input bit with_clear);
    bit seen = 0;
    alu_in   = val;
    key_n    = 1'b0;
    scroll_n = with_scroll ? 1'b0 : 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (cap_pulse) seen = 1;
    end
    if (!seen) checkOutput("cap_timeout", 32'(seen), 32'd1);
    clear = with_clear;
    tick();
    clear    = 1'b0;
    key_n    = 1'b1;
    scroll_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic pressScroll();
    scroll_n = 1'b0;
    repeat (5) tick();
    scroll_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    alu_in = 8'h00; key_n = 1'b1; scroll_n = 1'b1; clear = 1'b0;
    #2;
    doReset();
    checkOutput("rst_q", 32'(q), 32'h0);
    checkOutput("rst_cap", 32'(cap_pulse), 32'h0);
    checkOutput("rst_hist_q", 32'(hist_q), 32'h0);
    checkOutput("rst_idx", 32'(hist_idx), 32'h0);
    checkOutput("rst_count", 32'(count), 32'h0);
    checkOutput("rst_full", 32'(full), 32'h0);
    repeat (4) tick();

    // Latency: pulse after SYNC+1 edges, one cycle wide, q on the next edge
    alu_in = 8'h3C;
    key_n  = 1'b0;
    tick(); checkOutput("lat_e1", 32'(cap_pulse), 32'd0);
    tick(); checkOutput("lat_e2", 32'(cap_pulse), 32'd0);
    tick(); checkOutput("lat_e3", 32'(cap_pulse), 32'd1);
    checkOutput("lat_q_hold", 32'(q), 32'h0);
    tick(); checkOutput("lat_e4", 32'(cap_pulse), 32'd0);
    checkOutput("lat_q", 32'(q), 32'h3C);
    checkOutput("lat_count", 32'(count), 32'd1);
    checkOutput("lat_hist_q", 32'(hist_q), 32'h3C);
    key_n = 1'b1;
    repeat (4) tick();

    for (int v = 1; v <= 5; v++) applyStimulus(8'(v), 0, 0);
    checkOutput("fill_q", 32'(q), 32'h05);
    checkOutput("fill_hist_q", 32'(hist_q), 32'h05);
`ifdef ALU_HIST_EN
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_full", 32'(full), 32'd1);
    pressScroll();
    checkOutput("scr1_idx", 32'(hist_idx), 32'd1);
    checkOutput("scr1_val", 32'(hist_q), 32'h04);
    pressScroll();
    checkOutput("scr2_val", 32'(hist_q), 32'h03);
    pressScroll();
    checkOutput("scr3_idx", 32'(hist_idx), 32'd3);
    checkOutput("scr3_val", 32'(hist_q), 32'h02);
    pressScroll();
    checkOutput("scr4_idx", 32'(hist_idx), 32'd0);
    checkOutput("scr4_val", 32'(hist_q), 32'h05);
    pressScroll();
    checkOutput("pre_sc_idx", 32'(hist_idx), 32'd1);
`else
    checkOutput("fill_count", 32'(count), 32'd1);
    checkOutput("fill_full", 32'(full), 32'd0);
    pressScroll();
    checkOutput("scr_idx", 32'(hist_idx), 32'd0);
    checkOutput("scr_hist_q", 32'(hist_q), 32'h05);
`endif

    // Scroll and capture together: scroll dropped
    applyStimulus(8'h66, 1, 0);
    checkOutput("sc_q", 32'(q), 32'h66);
    checkOutput("sc_idx", 32'(hist_idx), 32'd0);
    checkOutput("sc_hist_q", 32'(hist_q), 32'h66);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clr_q", 32'(q), 32'h66);
`ifdef ALU_HIST_EN
    checkOutput("clr_count", 32'(count), 32'd0);
    checkOutput("clr_hist_q", 32'(hist_q), 32'h0);
    checkOutput("clr_full", 32'(full), 32'd0);
    pressScroll();
    checkOutput("clr_scr_idx", 32'(hist_idx), 32'd0);
`else
    checkOutput("clr_count", 32'(count), 32'd1);
    checkOutput("clr_hist_q", 32'(hist_q), 32'h66);
`endif

    applyStimulus(8'h11, 0, 0);
    applyStimulus(8'h22, 0, 0);
    applyStimulus(8'h33, 0, 0);
`ifdef ALU_HIST_EN
    checkOutput("three_count", 32'(count), 32'd3);
    pressScroll();
    checkOutput("three_scr", 32'(hist_q), 32'h22);
`endif
    applyStimulus(8'hA5, 0, 1);
    checkOutput("cc_q", 32'(q), 32'hA5);
    checkOutput("cc_count", 32'(count), 32'd1);
    checkOutput("cc_idx", 32'(hist_idx), 32'd0);
    checkOutput("cc_hist_q", 32'(hist_q), 32'hA5);
    applyStimulus(8'h5A, 0, 0);
`ifdef ALU_HIST_EN
    checkOutput("cc2_count", 32'(count), 32'd2);
    checkOutput("cc2_hist_q", 32'(hist_q), 32'h5A);
    pressScroll();
    checkOutput("cc2_scr", 32'(hist_q), 32'hA5);
`else
    checkOutput("cc2_hist_q", 32'(hist_q), 32'h5A);
`endif

    // Long hold gives one pulse; a fresh press gives another
    alu_in = 8'h99;
    key_n  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cap_pulse) pulses++;
    end
    checkOutput("hold_pulses", 32'(pulses), 32'd1);
    checkOutput("hold_q", 32'(q), 32'h99);
    key_n = 1'b1;
    repeat (4) tick();
    alu_in = 8'h77;
    key_n  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cap_pulse) pulses++;
    end
    checkOutput("repress_pulses", 32'(pulses), 32'd1);
    checkOutput("repress_q", 32'(q), 32'h77);

    // Key still held through reset: no capture afterwards
    doReset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cap_pulse) pulses++;
    end
    checkOutput("held_rst_pulses", 32'(pulses), 32'd0);
    checkOutput("held_rst_q", 32'(q), 32'h0);
    checkOutput("held_rst_count", 32'(count), 32'd0);
    key_n = 1'b1;
    repeat (4) tick();
    applyStimulus(8'hC3, 0, 0);
    checkOutput("post_rst_q", 32'(q), 32'hC3);
    checkOutput("post_rst_count", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_result_reg.md
# alu_result_reg

Registered result stage that sits directly downstream of the 8-bit ALU. It samples the ALU output on a debounced-free, synchronized pushbutton press and holds it in the result register. That register's low nibble is fed back as the ALU's B operand. It also keeps a small ring-buffer history of captured results that can be scrolled for display on LEDs/7-seg.

## Interface
- WIDTH, 8, result width (matches ALU output)
- DEPTH, 4, history entries; power of two, ≥2
- SYNC_STAGES, 2, synchronizer flops per pushbutton input (≥2)

- clk  input  1  system clock; all state on rising edge
- reset  input  1  synchronous, active-high; one clock, sampled on rising edge of clk
- alu_in  input  WIDTH  current ALU result
- key_n  input  1  raw active-low capture pushbutton (asynchronous)
- scroll_n  input  1  raw active-low history-scroll pushbutton (asynchronous)
- clear  input  1  synchronous level; empties history, leaves q untouched
- q  output  WIDTH  result register; q[3:0] drives ALU B operand
- cap_pulse  output  1  one-cycle strobe marking a capture
- hist_q  output  WIDTH  history entry selected by hist_idx; 0 when empty
- hist_idx  output  log2(DEPTH)  age of displayed entry, 0 = newest
- count  output  log2(DEPTH)+1  valid history entries, saturates at DEPTH
- full  output  1  count == DEPTH

## Operation
- key_n and scroll_n each pass through SYNC_STAGES flops plus one edge flop. A synchronized 1→0 transition gives a one-cycle internal pulse (cap, scr). cap_pulse is cap.
- Capture (cap=1): q ← alu_in. The history entry at wr_ptr ← alu_in, and wr_ptr ← wr_ptr+1 mod DEPTH. count ← min(count+1, DEPTH). hist_idx ← 0.
- When full, a capture overwrites the oldest entry. count stays DEPTH.
- Scroll (scr=1, cap=0): if count==0, hist_idx stays 0. Otherwise hist_idx ← (hist_idx+1) mod count, wrapping from oldest back to newest.
- hist_q = mem[(wr_ptr−1−hist_idx) mod DEPTH] combinationally when count>0, else 0.
- Clear (clear=1): count ← 0, hist_idx ← 0, wr_ptr ← 0.
- Clear with a simultaneous cap: the history is emptied and then the new value is written at index 0. Result is count=1, wr_ptr=1, and q is updated.
- Priority: reset > clear > cap > scr. Scroll in the same cycle as a capture is dropped.
- No arithmetic on data. Values are stored bit-exact. Pointer and index arithmetic is modulo DEPTH.

## Timing
- Reset values: q=0, cap_pulse=0, hist_q=0, hist_idx=0, count=0, full=0, wr_ptr=0.
- All sync and edge flops reset to 0 ("pressed"). A button held through reset produces no capture after release of reset; only a later press does.
- Latency: key_n falling (stable) → cap_pulse high after SYNC_STAGES+1 rising edges, for exactly one cycle.
- q and history update on the edge that ends the cap_pulse cycle. The new q is visible on the next cycle.
- Feedback path: alu_in is sampled once per capture. Combinational change of alu_in caused by the new q does not recapture.
- A button held low produces exactly one pulse. Another pulse requires release (synchronized 1) and a new press.
- Reset asserted mid-press or mid-scroll aborts any pending pulse.

## Configuration
- ALU_HIST_EN defined: history buffer, scroll logic, count/full/hist_idx as above.
- ALU_HIST_EN undefined: no memory or scroll logic. scroll_n and clear are ignored.
  - hist_q = q and hist_idx = 0.
  - count = 0 after reset, 1 after the first capture.
  - full = 0 always.
  - q and cap_pulse behaviour are unchanged.

## Test plan
- Reset, then press key_n with alu_in=8'h3C → cap_pulse one cycle at SYNC_STAGES+1 edges. Then q=8'h3C, count=1, hist_q=8'h3C.
- Capture 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 (DEPTH=4) → count=4, full=1, hist_q=8'h05. Scrolling three times shows 8'h04, 8'h03, 8'h02, and a fourth scroll returns to 8'h05; 8'h01 is lost.
- Hold key_n low for 20 cycles → exactly one cap_pulse. Release and press again → second pulse.
- key_n held low across reset → no cap_pulse after reset deasserts; q stays 0.
- clear and cap in the same cycle with count=3, alu_in=8'hA5 → count=1, hist_idx=0, hist_q=8'hA5, q=8'hA5.
- Scroll and cap in the same cycle → hist_idx=0 and capture performed. With ALU_HIST_EN undefined, a scroll press leaves hist_idx=0 and hist_q=q.
